// File: rtl/scratchpad_streamer_if.sv
// Stream bundle carried out of scratchpad_streamer: one BUS_WIDTH word per handshake.
//   data  : stream word
//   valid : data/last are valid
//   ready : consumer accepts the word when valid & ready
//   last  : current word is the final element of the matrix
// master drives data/valid/last, slave drives ready.
interface scratchpad_streamer_if #(
   parameter int unsigned BUS_WIDTH = 16
);
   logic [BUS_WIDTH-1:0] data;
   logic                 valid;
   logic                 ready;
   logic                 last;

   modport master (output data, output valid, output last, input ready);
   modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/scratchpad_streamer.sv
// Walks one stored matrix of the scratchpad element by element, row-major, and emits the
// elements as a valid/ready stream.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   start_i, target_i   : request to stream matrix target_i (sampled only while idle)
//   n_rows_i, n_cols_i  : dimensions to stream, legal 1..MAX_DIM
//   sp_address_o        : scratchpad read target
//   sp_sub_address_o    : scratchpad element index {row,col}
//   sp_data_i           : scratchpad read data, combinational from the address
//   stream_io           : data/valid/ready/last stream (master side)
//   busy_o              : high in every state except idle
//   done_o              : one-cycle pulse after the final word is accepted
//   err_o               : one-cycle pulse on a rejected start
module scratchpad_streamer #(
   parameter int unsigned BUS_WIDTH   = 16,
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned SP_NTARGETS = 2,
   localparam int unsigned MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
   localparam int unsigned PTR_W      = $clog2(MAX_DIM),
   localparam int unsigned DIM_W      = PTR_W + 1
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   input  logic [1:0]             target_i,
   input  logic [DIM_W-1:0]       n_rows_i,
   input  logic [DIM_W-1:0]       n_cols_i,
   output logic [1:0]             sp_address_o,
   output logic [2*PTR_W-1:0]     sp_sub_address_o,
   input  logic [BUS_WIDTH-1:0]   sp_data_i,
   scratchpad_streamer_if.master  stream_io,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   err_o
);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StFetch = 2'd1;
   localparam logic [1:0] StSend  = 2'd2;
   localparam logic [1:0] StDone  = 2'd3;

   localparam logic [DIM_W-1:0] MaxDim   = DIM_W'(MAX_DIM);
   localparam logic [2:0]       NTargets = 3'(SP_NTARGETS);

   logic [1:0]           state_q, state_d;
   logic [1:0]           target_q, target_d;
   logic [DIM_W-1:0]     n_rows_q, n_rows_d;
   logic [DIM_W-1:0]     n_cols_q, n_cols_d;
   logic [PTR_W-1:0]     row_q, row_d;
   logic [PTR_W-1:0]     col_q, col_d;
   logic [BUS_WIDTH-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 last_q, last_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;

   logic start_legal;
   logic at_last_row;
   logic at_last_col;
   logic load;

   assign start_legal = ({1'b0, target_i} < NTargets) &&
                        (n_rows_i != '0) && (n_rows_i <= MaxDim) &&
                        (n_cols_i != '0) && (n_cols_i <= MaxDim);

   assign at_last_row = ({1'b0, row_q} == n_rows_q - DIM_W'(1));
   assign at_last_col = ({1'b0, col_q} == n_cols_q - DIM_W'(1));

   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      n_rows_d = n_rows_q;
      n_cols_d = n_cols_q;
      row_d    = row_q;
      col_d    = col_q;
      data_d   = data_q;
      valid_d  = valid_q;
      last_d   = last_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      load     = 1'b0;

      case (state_q)
         StIdle: begin
            if (start_i) begin
               if (start_legal) begin
                  target_d = target_i;
                  n_rows_d = n_rows_i;
                  n_cols_d = n_cols_i;
                  row_d    = '0;
                  col_d    = '0;
                  state_d  = StFetch;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         StFetch: begin
            load    = 1'b1;
            state_d = StSend;
         end
         StSend: begin
            if (valid_q && stream_io.ready) begin
               if (last_q) begin
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = StDone;
               end else begin
                  // Refill on the accepting edge keeps one word per cycle.
                  load = 1'b1;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Pointers always address the next element, so sp_data_i is already the word to load.
      if (load) begin
         data_d  = sp_data_i;
         valid_d = 1'b1;
         last_d  = at_last_row && at_last_col;
         if (at_last_col) begin
            col_d = '0;
            row_d = row_q + PTR_W'(1);
         end else begin
            col_d = col_q + PTR_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= StIdle;
         target_q <= '0;
         n_rows_q <= '0;
         n_cols_q <= '0;
         row_q    <= '0;
         col_q    <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         n_rows_q <= n_rows_d;
         n_cols_q <= n_cols_d;
         row_q    <= row_d;
         col_q    <= col_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         last_q   <= last_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign sp_address_o     = target_q;
   assign sp_sub_address_o = {row_q, col_q};
   assign stream_io.data   = data_q;
   assign stream_io.valid  = valid_q;
   assign stream_io.last   = last_q;
   assign busy_o           = (state_q != StIdle);
   assign done_o           = done_q;
   assign err_o            = err_q;

endmodule
